// File: rtl/histogram_readout_controller_if.sv
// Memory-controller command port and output-FIFO port used by the histogram readout controller.
interface histogram_readout_controller_if;
  logic        pX_ready;
  logic [31:0] pX_data_out;
  logic [31:0] pX_data_in;
  logic        pX_data_ready;
  logic [29:0] pX_addr;
  logic        pX_read_write;
  logic        pX_mem_op;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;

  modport master (
    input  pX_ready, pX_data_in, pX_data_ready, fifo_full,
    output pX_data_out, pX_addr, pX_read_write, pX_mem_op, fifo_din, fifo_wr_en
  );

  modport slave (
    output pX_ready, pX_data_in, pX_data_ready, fifo_full,
    input  pX_data_out, pX_addr, pX_read_write, pX_mem_op, fifo_din, fifo_wr_en
  );
endinterface

// File: rtl/histogram_readout_controller.sv
// Raster-scans the DDR2 histogram, streams each (clipped) count into the output FIFO
// framed by header/trailer markers, and optionally zeroes every cell after reading it.
module histogram_readout_controller #(
  parameter int X_BITS        = 10,
  parameter int Y_BITS        = 10,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  histogram_readout_controller_if.master bus
);

  localparam logic [31:0] HEADER_WORD  = 32'hFFFF_FFFF;
  localparam logic [31:0] TRAILER_OK   = 32'hFFFF_FFFE;
  localparam logic [31:0] TRAILER_ABRT = 32'hFFFF_FFFD;
  localparam logic [31:0] CLIP_MAX     = 32'hFFFF_FFFC;

  typedef enum logic [3:0] {
    IDLE, HEADER, RD_CMD, RD_WAIT, PUSH, CLR_CMD, CLR_WAIT, NEXT, TRAILER, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [1:0]        phase_q, phase_d;
  logic [31:0]       count_q, count_d;
  logic              abort_flag_q, abort_flag_d;
  logic              busy_q, busy_d;

  logic [9:0]        x_ext, y_ext;
  logic              last_cell;
  logic              cmd_strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= '0;
      count_q      <= '0;
      abort_flag_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      count_q      <= count_d;
      abort_flag_q <= abort_flag_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    x_ext              = '0;
    y_ext              = '0;
    x_ext[X_BITS-1:0]  = x_q;
    y_ext[Y_BITS-1:0]  = y_q;
  end

  // The first strobe cycle waits for pX_ready; later cycles of the burst are unconditional.
  assign cmd_strobe = (phase_q != 2'd0) || bus.pX_ready;
  assign last_cell  = (x_q == '1) && (y_q == '1);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    count_d      = count_q;
    abort_flag_d = abort_flag_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d          = '0;
          y_d          = '0;
          phase_d      = '0;
          abort_flag_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = HEADER;
        end
      end
      HEADER:  if (!bus.fifo_full) state_d = RD_CMD;
      RD_CMD: begin
        if (cmd_strobe) begin
          if (phase_q == 2'd2) begin
            phase_d = '0;
            state_d = RD_WAIT;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      RD_WAIT: begin
        if (bus.pX_data_ready) begin
          count_d = (bus.pX_data_in >= CLIP_MAX) ? CLIP_MAX : bus.pX_data_in;
          state_d = PUSH;
        end
      end
      PUSH:    if (!bus.fifo_full) state_d = CLEAR_ON_READ ? CLR_CMD : NEXT;
      CLR_CMD: begin
        if (cmd_strobe) begin
          if (phase_q == 2'd1) begin
            phase_d = '0;
            state_d = CLR_WAIT;
          end else begin
            phase_d = 2'd1;
          end
        end
      end
      CLR_WAIT: if (bus.pX_ready) state_d = NEXT;
      NEXT: begin
        if (abort) begin
          abort_flag_d = 1'b1;
          state_d      = TRAILER;
        end else if (last_cell) begin
          state_d = TRAILER;
        end else begin
          x_d = x_q + 1'b1;
          if (x_q == '1) y_d = y_q + 1'b1;
          state_d = RD_CMD;
        end
      end
      TRAILER: if (!bus.fifo_full) state_d = DONE;
      DONE: begin
        busy_d       = 1'b0;
        abort_flag_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pX_mem_op     = 1'b0;
    bus.pX_read_write = 1'b1;
    bus.fifo_wr_en    = 1'b0;
    bus.fifo_din      = '0;
    done              = 1'b0;
    case (state_q)
      HEADER: begin
        bus.fifo_din   = HEADER_WORD;
        bus.fifo_wr_en = !bus.fifo_full;
      end
      RD_CMD:  bus.pX_mem_op = cmd_strobe;
      PUSH: begin
        bus.fifo_din   = count_q;
        bus.fifo_wr_en = !bus.fifo_full;
      end
      CLR_CMD: begin
        bus.pX_mem_op     = cmd_strobe;
        bus.pX_read_write = !cmd_strobe;
      end
      TRAILER: begin
        bus.fifo_din   = abort_flag_q ? TRAILER_ABRT : TRAILER_OK;
        bus.fifo_wr_en = !bus.fifo_full;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.pX_addr     = {8'd0, y_ext, x_ext, 2'b00};
  assign bus.pX_data_out = '0;
  assign busy            = busy_q;

endmodule

// File: tb/tb_histogram_readout_controller.sv
// Bench for the histogram readout controller: a clear-on-read and a read-only instance,
// each with its own DDR2 command model, sharing one output-stream scoreboard.
module tb_histogram_readout_controller;

  localparam int XB     = 2;
  localparam int YB     = 2;
  localparam int NC     = 16;
  localparam int BUDGET = 4000;

  typedef struct {
    logic [31:0] cell_val;
    logic [31:0] exp_word;
  } vec_t;

  vec_t plain_tbl [NC];
  vec_t edge_tbl  [NC];

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start_v, abort_v;
  logic        fifo_full, ready_hold, preload;
  int          rd_delay;
  logic [31:0] init_mem [NC];

  logic [1:0]  busy_v, done_v, wr_en_v, rw_v, op_v;
  logic [31:0] din_v  [2];
  logic [31:0] dout_v [2];
  logic [29:0] addr_v [2];

  int          checks = 0;
  int          errors = 0;
  int          nwr = 0;
  int          done_cnt [2] = '{0, 0};
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // Each instance gets a memory model that checks strobe length and address stability.
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    histogram_readout_controller_if bus_if ();

    logic [31:0] mem [NC];
    int          rd_cnt = 0, wr_cnt = 0, proto_err = 0, run_len = 0, dly = 0, busy_cyc = 0;
    logic        prev_op = 1'b0, run_rw = 1'b1, pend = 1'b0, drdy = 1'b0;
    logic [29:0] run_addr = '0;
    logic [31:0] run_dat = '0, dat = '0;
    logic [3:0]  idx;

    assign idx                  = {run_addr[13:12], run_addr[3:2]};
    assign bus_if.pX_ready      = (busy_cyc == 0) && !pend && !ready_hold;
    assign bus_if.pX_data_ready = drdy;
    assign bus_if.pX_data_in    = dat;
    assign bus_if.fifo_full     = fifo_full;
    assign wr_en_v[g]           = bus_if.fifo_wr_en;
    assign din_v[g]             = bus_if.fifo_din;
    assign rw_v[g]              = bus_if.pX_read_write;
    assign op_v[g]              = bus_if.pX_mem_op;
    assign dout_v[g]            = bus_if.pX_data_out;
    assign addr_v[g]            = bus_if.pX_addr;

    histogram_readout_controller #(
      .X_BITS(XB), .Y_BITS(YB), .CLEAR_ON_READ(g == 0)
    ) dut (
      .clk(clk), .reset(reset), .start(start_v[g]), .abort(abort_v[g]),
      .busy(busy_v[g]), .done(done_v[g]), .bus(bus_if.master)
    );

    always @(posedge clk) begin
      drdy <= 1'b0;
      if (preload) begin
        for (int i = 0; i < NC; i++) mem[i] <= init_mem[i];
        rd_cnt    <= 0;
        wr_cnt    <= 0;
        proto_err <= 0;
      end
      if (reset || preload) begin
        prev_op  <= 1'b0;
        pend     <= 1'b0;
        busy_cyc <= 0;
        run_len  <= 0;
      end else begin
        prev_op <= op_v[g];
        if (busy_cyc > 0) busy_cyc <= busy_cyc - 1;
        if (op_v[g]) begin
          if (!prev_op) begin
            run_rw   <= rw_v[g];
            run_addr <= addr_v[g];
            run_dat  <= dout_v[g];
            run_len  <= 1;
            if (!bus_if.pX_ready || addr_v[g][1:0] != 2'b00 || addr_v[g][11:4] != 8'd0 ||
                addr_v[g][29:14] != 16'd0)
              proto_err <= proto_err + 1;
          end else begin
            run_len <= run_len + 1;
            if (addr_v[g] != run_addr || rw_v[g] != run_rw || dout_v[g] != run_dat)
              proto_err <= proto_err + 1;
          end
        end else if (prev_op) begin
          if (run_rw) begin
            if (run_len != 3) proto_err <= proto_err + 1;
            rd_cnt <= rd_cnt + 1;
            pend   <= 1'b1;
            dly    <= rd_delay;
          end else begin
            if (run_len != 2) proto_err <= proto_err + 1;
            wr_cnt   <= wr_cnt + 1;
            mem[idx] <= run_dat;
            busy_cyc <= 3;
          end
        end
        if (pend) begin
          if (dly == 0) begin
            drdy <= 1'b1;
            dat  <= mem[idx];
            pend <= 1'b0;
          end else begin
            dly <= dly - 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout after %0d cycles, required event", name, BUDGET);
  endtask

  // FIFO side of the scoreboard, sampled mid-cycle so the write strobe is settled.
  task automatic monitor();
    for (int g = 0; g < 2; g++) begin
      if (done_v[g]) done_cnt[g]++;
      if (fifo_full) begin
        checkOutput("no_wr_while_full", 32'(wr_en_v[g]), 32'd0);
      end else if (wr_en_v[g]) begin
        nwr++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %h, required no write", din_v[g]);
        end else begin
          checkOutput("stream_word", din_v[g], exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int g, input bit use_edge, input int n_cells,
                               input logic [31:0] trailer, input bit with_trailer);
    for (int i = 0; i < NC; i++) init_mem[i] = use_edge ? edge_tbl[i].cell_val : plain_tbl[i].cell_val;
    preload = 1'b1;
    tick();
    preload = 1'b0;
    exp_q.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < n_cells; i++) exp_q.push_back(use_edge ? edge_tbl[i].exp_word : plain_tbl[i].exp_word);
    if (with_trailer) exp_q.push_back(trailer);
    start_v[g] = 1'b1;
    tick();
    start_v[g] = 1'b0;
    checkOutput("busy_after_start", 32'(busy_v[g]), 32'd1);
  endtask

  task automatic waitDone(input int g);
    int c0;
    int n;
    c0 = done_cnt[g];
    n  = 0;
    while (done_cnt[g] == c0 && n < BUDGET) begin
      tick();
      n++;
    end
    if (done_cnt[g] == c0) reportTimeout("wait_done");
    repeat (3) tick();
    checkOutput("done_single_pulse", 32'(done_cnt[g] - c0), 32'd1);
    checkOutput("busy_cleared", 32'(busy_v[g]), 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic waitRd0(input int target);
    int n;
    n = 0;
    while (gen_dut[0].rd_cnt < target && n < BUDGET) begin
      tick();
      n++;
    end
    if (gen_dut[0].rd_cnt < target) reportTimeout("wait_read");
  endtask

  task automatic checkResetValues();
    checkOutput("rst_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("rst_done", 32'(done_v[0]), 32'd0);
    checkOutput("rst_addr", 32'(addr_v[0]), 32'd0);
    checkOutput("rst_rw", 32'(rw_v[0]), 32'd1);
    checkOutput("rst_mem_op", 32'(op_v[0]), 32'd0);
    checkOutput("rst_data_out", dout_v[0], 32'd0);
    checkOutput("rst_fifo_din", din_v[0], 32'd0);
    checkOutput("rst_fifo_wr_en", 32'(wr_en_v[0]), 32'd0);
  endtask

  initial begin
    int n0;
    int n;
    int d0;
    reset      = 1'b1;
    start_v    = '0;
    abort_v    = '0;
    fifo_full  = 1'b0;
    ready_hold = 1'b0;
    preload    = 1'b0;
    rd_delay   = 2;
    for (int i = 0; i < NC; i++) begin
      plain_tbl[i] = '{32'(100 + i), 32'(100 + i)};
      edge_tbl[i]  = '{32'(100 + i), 32'(100 + i)};
    end
    edge_tbl[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    edge_tbl[2]  = '{32'hFFFF_FFFC, 32'hFFFF_FFFC};
    edge_tbl[3]  = '{32'hFFFF_FFFB, 32'hFFFF_FFFB};
    edge_tbl[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFC};
    edge_tbl[15] = '{32'h0000_0000, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    reset = 1'b0;
    tick();

    $display("[TB] full frame, clear on read");
    applyStimulus(0, 1'b0, NC, 32'hFFFF_FFFE, 1'b1);
    waitDone(0);
    for (int i = 0; i < NC; i++) checkOutput("cell_cleared", gen_dut[0].mem[i], 32'd0);
    checkOutput("read_cmds", 32'(gen_dut[0].rd_cnt), 32'd16);
    checkOutput("write_cmds", 32'(gen_dut[0].wr_cnt), 32'd16);
    checkOutput("protocol", 32'(gen_dut[0].proto_err), 32'd0);

    $display("[TB] full frame, read only");
    applyStimulus(1, 1'b0, NC, 32'hFFFF_FFFE, 1'b1);
    waitDone(1);
    for (int i = 0; i < NC; i++) checkOutput("cell_kept", gen_dut[1].mem[i], plain_tbl[i].cell_val);
    checkOutput("ro_read_cmds", 32'(gen_dut[1].rd_cnt), 32'd16);
    checkOutput("ro_write_cmds", 32'(gen_dut[1].wr_cnt), 32'd0);
    checkOutput("ro_protocol", 32'(gen_dut[1].proto_err), 32'd0);

    $display("[TB] count clipping");
    applyStimulus(0, 1'b1, NC, 32'hFFFF_FFFE, 1'b1);
    waitDone(0);
    checkOutput("clipped_cell_cleared", gen_dut[0].mem[1], 32'd0);
    checkOutput("clip_protocol", 32'(gen_dut[0].proto_err), 32'd0);

    $display("[TB] fifo full stall");
    applyStimulus(0, 1'b0, NC, 32'hFFFF_FFFE, 1'b1);
    n0 = nwr;
    waitRd0(6);
    fifo_full = 1'b1;
    repeat (20) tick();
    fifo_full = 1'b0;
    waitDone(0);
    checkOutput("words_in_frame", 32'(nwr - n0), 32'd18);

    $display("[TB] abort during cell 3");
    applyStimulus(0, 1'b0, 4, 32'hFFFF_FFFD, 1'b1);
    waitRd0(4);
    abort_v[0] = 1'b1;
    waitDone(0);
    abort_v[0] = 1'b0;
    for (int i = 0; i < NC; i++)
      checkOutput("abort_cell", gen_dut[0].mem[i], (i < 4) ? 32'd0 : plain_tbl[i].cell_val);
    checkOutput("abort_reads", 32'(gen_dut[0].rd_cnt), 32'd4);
    checkOutput("abort_writes", 32'(gen_dut[0].wr_cnt), 32'd4);

    $display("[TB] slow memory");
    rd_delay = 7;
    applyStimulus(0, 1'b0, NC, 32'hFFFF_FFFE, 1'b1);
    ready_hold = 1'b1;
    repeat (10) tick();
    ready_hold = 1'b0;
    waitDone(0);
    checkOutput("slow_protocol", 32'(gen_dut[0].proto_err), 32'd0);
    checkOutput("slow_reads", 32'(gen_dut[0].rd_cnt), 32'd16);
    checkOutput("slow_writes", 32'(gen_dut[0].wr_cnt), 32'd16);

    $display("[TB] reset mid frame");
    rd_delay = 2;
    applyStimulus(0, 1'b0, 3, 32'hFFFF_FFFE, 1'b0);
    n0 = nwr;
    n  = 0;
    d0 = done_cnt[0];
    while (nwr < n0 + 4 && n < BUDGET) begin
      tick();
      n++;
    end
    if (nwr < n0 + 4) reportTimeout("wait_words");
    reset = 1'b1;
    #1;
    checkResetValues();
    repeat (2) tick();
    reset = 1'b0;
    repeat (40) tick();
    checkOutput("no_trailer_after_reset", 32'(exp_q.size()), 32'd0);
    checkOutput("no_done_after_reset", 32'(done_cnt[0] - d0), 32'd0);
    checkOutput("idle_after_reset", 32'(busy_v[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/histogram_readout_controller.md
Name: histogram_readout_controller

Overview:
- Scans the 2-D histogram held in DDR2 cell by cell, in raster order, and streams every count word into an output FIFO for host transfer (USB/Ethernet bridge).
- Optionally zeroes each cell after reading it, so a new acquisition starts from an empty image.
- Uses its own DDR2 memory-controller port, with the same address layout and command handshake as the histogram-fill path.
- busy is used externally to gate the histogram-fill path while a readout runs.

Parameters:
- X_BITS, 10, number of x-bin index bits (1..10); x range 0..2^X_BITS-1.
- Y_BITS, 10, number of y-bin index bits (1..10); y range 0..2^Y_BITS-1.
- CLEAR_ON_READ, 1, 1 = write 0 back to each cell after reading it; 0 = read only.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame readout when idle.
- abort  in  1  level; requests early frame termination.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the trailer has been written.
- pX_ready  in  1  memory controller ready.
- pX_data_out  out  32  write data to memory.
- pX_data_in  in  32  read data from memory.
- pX_data_ready  in  1  read data valid.
- pX_addr  out  30  word address.
- pX_read_write  out  1  1 = read, 0 = write.
- pX_mem_op  out  1  command strobe.
- fifo_din  out  32  output FIFO data.
- fifo_wr_en  out  1  output FIFO write strobe.
- fifo_full  in  1  output FIFO full flag.

Behaviour:
- Reset values: busy 0, done 0, pX_data_out 0, pX_addr 0, pX_read_write 1, pX_mem_op 0, fifo_din 0, fifo_wr_en 0. The state machine goes to IDLE.
- Reset mid-frame: abandon immediately. No trailer is written; the FIFO is not flushed.
- Address: pX_addr[1:0]=00, [11:2]=x zero-extended to 10 bits, [21:12]=y zero-extended to 10 bits, [29:22]=0.
- Scan order: x is the inner index, y the outer. Readout starts at (0,0) and ends at (2^X_BITS-1, 2^Y_BITS-1).
- Defaults every cycle: pX_mem_op=0, pX_read_write=1, fifo_wr_en=0, done=0.
- FIFO write rule: fifo_wr_en is asserted for exactly one cycle, and only in a cycle where fifo_full=0. While fifo_full=1 the block holds its state with no write. fifo_din is valid in the same cycle as fifo_wr_en.
- Read command: wait for pX_ready=1. Then drive pX_mem_op=1 and pX_read_write=1 for 3 consecutive cycles with pX_addr stable. After the strobe, capture pX_data_in on the first cycle with pX_data_ready=1.
- Write command: wait for pX_ready=1. Then drive pX_mem_op=1 and pX_read_write=0 for 2 consecutive cycles with pX_addr and pX_data_out stable. The write is complete on the first subsequent cycle with pX_ready=1.
- Markers: header word 32'hFFFFFFFF; normal trailer 32'hFFFFFFFE; abort trailer 32'hFFFFFFFD.
- Count clipping: any count >= 32'hFFFFFFFC is emitted as 32'hFFFFFFFC, so data words never alias a marker. Memory contents are not altered by clipping.
- States:
  - IDLE: on start, load x=0, y=0, set busy=1, go to HEADER. start is ignored while busy.
  - HEADER: write the header word to the FIFO, then go to RD_CMD.
  - RD_CMD: issue the read command, then go to RD_WAIT.
  - RD_WAIT: capture the read data, then go to PUSH.
  - PUSH: write the (clipped) count to the FIFO. Next state is CLR_CMD if CLEAR_ON_READ=1, otherwise NEXT.
  - CLR_CMD: write 0 to the same address, then go to CLR_WAIT.
  - CLR_WAIT: wait for write completion, then go to NEXT.
  - NEXT:
    - If abort=1, go to TRAILER with the abort flag set.
    - Otherwise, if this was the last cell, go to TRAILER.
    - Otherwise advance the index: x+1; when x wraps from 2^X_BITS-1 to 0, y+1. Then go to RD_CMD.
  - TRAILER: write the normal or abort trailer to the FIFO, then go to DONE.
  - DONE: pulse done=1, busy=0, clear the abort flag, go to IDLE.
- abort is sampled only in NEXT. A cell is never left read-but-not-cleared.
- Simultaneous start and abort in IDLE: start is accepted. abort is honoured at the first NEXT only if it is still high then.
- Frame length: 2^(X_BITS+Y_BITS)+2 FIFO words when not aborted.

Test Plan:
- X_BITS=2, Y_BITS=2, CLEAR_ON_READ=1; memory preloaded with cell value = 100+index; start pulse -> FIFO receives 18 words: FFFFFFFF, then 100..115 in order (addresses 0x000, 0x004, 0x008, 0x00C, 0x1000, ...), then FFFFFFFE. All 16 cells read 0 afterwards; done pulses once.
- Same configuration with CLEAR_ON_READ=0 -> same 18-word stream; memory is unchanged; exactly 16 read commands and 0 write commands are observed.
- Cell value 32'hFFFFFFFF at (1,0) -> the data word emitted for that cell is FFFFFFFC; the memory cell is then cleared to 0.
- fifo_full held high for 20 cycles during PUSH of cell 5 -> no fifo_wr_en while full; the stream resumes with the correct value and no duplicate or lost words.
- abort raised during read of cell 3 -> cells 0..3 are emitted and cleared, then trailer FFFFFFFD, done pulses; cells 4..15 are untouched.
- pX_ready low for 10 cycles before a read, and pX_data_ready delayed 7 cycles -> pX_mem_op high exactly 3 cycles per read and 2 per write, with pX_addr stable throughout. reset asserted mid-frame -> all outputs return to reset values next edge, and no trailer is written.
